// File: rtl/ups_da.sv
// ups_da: SYNC-framed serial DAC write controller (DAC7512/AD5320 style).
// Takes one 12-bit code plus a 2-bit power-down mode per valid/ready handshake
// and shifts the 16-bit frame {2'b00, pd, data} out MSB first on SDO.
// The DAC samples SDO on falling SCLK edges. Every output is a register.
module ups_da #(
  parameter int unsigned CLK_DIV_LOG2 = 3  // SCLK half-period H = 2**CLK_DIV_LOG2 clk cycles
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] data_i,
  input  logic [1:0]  pd_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        sclk_o,
  output logic        sync_n_o,
  output logic        sdo_o
);

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StGap} state_e;

  // Every phase reload value is H-1, which is all ones at this width.
  localparam logic [CLK_DIV_LOG2-1:0] HalfM1 = '1;

  state_e                  state_q, state_d;
  logic [CLK_DIV_LOG2-1:0] cnt_q, cnt_d;
  logic [3:0]              bit_q, bit_d;
  // Bit 15 goes straight to SDO on load, so only bits 14..0 need storing.
  logic [14:0]             shreg_q, shreg_d;
  logic                    sclk_q, sclk_d;
  logic                    sync_n_q, sync_n_d;
  logic                    sdo_q, sdo_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;

  logic                    cnt_last;
  logic [15:0]             frame;

  assign cnt_last = (cnt_q == '0);
  assign frame    = {2'b00, pd_i, data_i};

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    sclk_d   = sclk_q;
    sync_n_d = sync_n_q;
    sdo_d    = sdo_q;
    ready_d  = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready_d  = 1'b1;
        sclk_d   = 1'b1;
        sync_n_d = 1'b1;
        sdo_d    = 1'b0;
        if (valid_i && ready_q) begin
          shreg_d  = frame[14:0];
          sdo_d    = frame[15];
          sync_n_d = 1'b0;
          ready_d  = 1'b0;
          cnt_d    = HalfM1;
          state_d  = StSetup;
        end
      end

      StSetup: begin
        if (cnt_last) begin
          sclk_d  = 1'b0;
          cnt_d   = HalfM1;
          bit_d   = 4'd15;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StShift: begin
        if (!cnt_last) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = HalfM1;
          if (!sclk_q) begin
            // Low phase over: rise and present the next bit (hold bit 0 at the end).
            sclk_d = 1'b1;
            if (bit_q != 4'd0) begin
              sdo_d   = shreg_q[14];
              shreg_d = {shreg_q[13:0], 1'b0};
            end
          end else if (bit_q == 4'd0) begin
            sync_n_d = 1'b1;
            sdo_d    = 1'b0;
            done_d   = 1'b1;
            state_d  = StGap;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q - 4'd1;
          end
        end
      end

      StGap: begin
        if (cnt_last) begin
          ready_d = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset to the idle pin levels.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= 4'd0;
      shreg_q  <= '0;
      sclk_q   <= 1'b1;
      sync_n_q <= 1'b1;
      sdo_q    <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      sclk_q   <= sclk_d;
      sync_n_q <= sync_n_d;
      sdo_q    <= sdo_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign ready_o  = ready_q;
  assign done_o   = done_q;
  assign sclk_o   = sclk_q;
  assign sync_n_o = sync_n_q;
  assign sdo_o    = sdo_q;

endmodule

// File: tb/tb_ups_da.sv
// Bench for ups_da: two instances (H=8 and H=2) share clock, reset and data.
// A negedge monitor decodes each DAC frame and checks it against a queue of
// frames pushed when the words are offered.
module tb_ups_da;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] data;
  logic [1:0]  pd;
  logic [1:0]  valid;
  logic [1:0]  ready, done, sclk, sync_n, sdo;

  always #5 clk = ~clk;

  ups_da #(.CLK_DIV_LOG2(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .pd_i(pd), .valid_i(valid[0]),
    .ready_o(ready[0]), .done_o(done[0]), .sclk_o(sclk[0]), .sync_n_o(sync_n[0]),
    .sdo_o(sdo[0])
  );

  ups_da #(.CLK_DIV_LOG2(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .pd_i(pd), .valid_i(valid[1]),
    .ready_o(ready[1]), .done_o(done[1]), .sclk_o(sclk[1]), .sync_n_o(sync_n[1]),
    .sdo_o(sdo[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];

  logic [1:0]  p_sclk  = 2'b11;
  logic [1:0]  p_sync  = 2'b11;
  logic [1:0]  p_ready = 2'b00;
  logic [15:0] cap[2]        = '{16'h0, 16'h0};
  int          falls[2]      = '{0, 0};
  int          fall_at[2]    = '{0, 0};
  int          rise_at[2]    = '{0, 0};
  int          done_at[2]    = '{0, 0};
  int          ready_at[2]   = '{0, 0};
  int          done_cnt[2]   = '{0, 0};
  int          frames[2]     = '{0, 0};
  int          idle_edges[2] = '{0, 0};
  int          last_edge[2]  = '{0, 0};
  int          half_bad[2]   = '{0, 0};
  int          overlap       = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Frame decoder: samples SDO on SCLK falls while SYNC is low.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ready[d] && done[d]) overlap++;
      if (ready[d] && !p_ready[d]) ready_at[d] = cyc;
      if (done[d]) begin
        done_at[d] = cyc;
        done_cnt[d]++;
      end
      if (sync_n[d] && p_sync[d] && (sclk[d] != p_sclk[d])) idle_edges[d]++;
      if (!sync_n[d] && p_sync[d]) begin
        fall_at[d]   = cyc;
        last_edge[d] = cyc;
        falls[d]     = 0;
        cap[d]       = 16'h0;
      end
      if (!sync_n[d] && !p_sync[d] && (sclk[d] != p_sclk[d])) begin
        if ((cyc - last_edge[d]) != ((d == 0) ? 8 : 2)) half_bad[d]++;
        last_edge[d] = cyc;
        if (!sclk[d]) begin
          cap[d] = {cap[d][14:0], sdo[d]};
          falls[d]++;
        end
      end
      if (sync_n[d] && !p_sync[d]) begin
        rise_at[d] = cyc;
        if (rst) begin
          // Aborted frame: drop its scoreboard entry without checking.
          if (d == 0 && q0.size() > 0) void'(q0.pop_front());
          if (d == 1 && q1.size() > 0) void'(q1.pop_front());
        end else begin
          logic [15:0] exp;
          int          n;
          n = (d == 0) ? q0.size() : q1.size();
          chk("sb_pending", (n > 0), 1);
          if (n > 0) begin
            exp = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("frame_data", cap[d], exp);
            chk("frame_falls", falls[d], 16);
          end
          frames[d]++;
        end
      end
      p_sync[d]  = sync_n[d];
      p_sclk[d]  = sclk[d];
      p_ready[d] = ready[d];
    end
  end

  // Offer one word; returns just after the accepting edge. hold keeps valid high.
  task automatic write(input int d, input logic [11:0] dat, input logic [1:0] p,
                       input bit hold);
    int n = 0;
    data     = dat;
    pd       = p;
    valid[d] = 1'b1;
    if (d == 0) q0.push_back({2'b00, p, dat});
    else        q1.push_back({2'b00, p, dat});
    while (!ready[d] && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("hs_timeout", (n < 3000), 1);
    @(posedge clk); #1;
    if (!hold) valid[d] = 1'b0;
  endtask

  task automatic wait_frames(input int d, input int target);
    int n = 0;
    while (!(frames[d] >= target && ready[d]) && n < 5000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("frame_timeout", (n < 5000), 1);
  endtask

  initial begin
    int n;
    int dc;
    rst   = 1'b1;
    valid = 2'b00;
    data  = 12'h0;
    pd    = 2'b00;

    // Reset levels held throughout reset.
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_sclk", sclk, 2'b11);
      chk("rst_sync_n", sync_n, 2'b11);
      chk("rst_sdo", sdo, 2'b00);
      chk("rst_ready", ready, 2'b00);
      chk("rst_done", done, 2'b00);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    chk("ready_after_rst", ready, 2'b11);
    repeat (20) @(negedge clk);
    #1;

    // Single write with frame timing.
    write(0, 12'hA5C, 2'b00, 1'b0);
    wait_frames(0, 1);
    chk("sync_low_len", rise_at[0] - fall_at[0], 264);
    chk("done_delay", done_at[0] - fall_at[0], 264);
    chk("ready_after_done", ready_at[0] - done_at[0], 8);
    chk("done_count1", done_cnt[0], 1);

    // Back-to-back with valid held high.
    write(0, 12'h000, 2'b11, 1'b1);
    write(0, 12'hFFF, 2'b11, 1'b0);
    wait_frames(0, 3);
    chk("done_count3", done_cnt[0], 3);

    // Input hold: second word offered while busy and changes data mid-frame.
    write(0, 12'h123, 2'b00, 1'b0);
    repeat (40) @(negedge clk);
    #1;
    chk("busy_not_ready", ready[0], 1'b0);
    write(0, 12'h456, 2'b00, 1'b0);
    wait_frames(0, 5);

    // Reset at the 7th SCLK fall.
    write(0, 12'h3C3, 2'b01, 1'b0);
    n = 0;
    while (!(falls[0] == 7 && !sync_n[0] && !sclk[0]) && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("fall7_timeout", (n < 3000), 1);
    dc  = done_cnt[0];
    rst = 1'b1;
    @(negedge clk); #1;
    chk("abort_sync_n", sync_n[0], 1'b1);
    chk("abort_sclk", sclk[0], 1'b1);
    chk("abort_sdo", sdo[0], 1'b0);
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (300) @(negedge clk);
    #1;
    chk("abort_no_done", done_cnt[0], dc);
    write(0, 12'h7FF, 2'b00, 1'b0);
    wait_frames(0, 6);
    chk("done_after_abort", done_cnt[0], dc + 1);

    // Fast divider instance: H = 2.
    write(1, 12'h800, 2'b00, 1'b0);
    wait_frames(1, 1);
    chk("h2_period", ready_at[1] - fall_at[1], 68);
    chk("h2_done", done_at[1] - fall_at[1], 66);
    chk("h2_half_period", half_bad[1], 0);

    chk("h8_half_period", half_bad[0], 0);
    chk("idle_edges0", idle_edges[0], 0);
    chk("idle_edges1", idle_edges[1], 0);
    chk("ready_done_overlap", overlap, 0);
    chk("sb_empty0", q0.size(), 0);
    chk("sb_empty1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
